// File: rtl/accelerator_dnc_pkg.sv
// Shared definitions for the DNC interface-vector parser: parser states,
// field identifiers and helpers for walking the fixed field order.
package accelerator_dnc_pkg;

   typedef enum logic [3:0] {
      ST_STARTER    = 4'd0,
      ST_K_READ     = 4'd1,
      ST_BETA_READ  = 4'd2,
      ST_K_WRITE    = 4'd3,
      ST_BETA_WRITE = 4'd4,
      ST_E          = 4'd5,
      ST_V          = 4'd6,
      ST_F          = 4'd7,
      ST_G_A        = 4'd8,
      ST_G_W        = 4'd9,
      ST_PI         = 4'd10
   } state_t;

   localparam int unsigned NUM_STATES = 11;

   localparam logic [3:0] FIELD_K_READ     = 4'd0;
   localparam logic [3:0] FIELD_BETA_READ  = 4'd1;
   localparam logic [3:0] FIELD_K_WRITE    = 4'd2;
   localparam logic [3:0] FIELD_BETA_WRITE = 4'd3;
   localparam logic [3:0] FIELD_E          = 4'd4;
   localparam logic [3:0] FIELD_V          = 4'd5;
   localparam logic [3:0] FIELD_F          = 4'd6;
   localparam logic [3:0] FIELD_G_A        = 4'd7;
   localparam logic [3:0] FIELD_G_W        = 4'd8;
   localparam logic [3:0] FIELD_PI         = 4'd9;

   // Number of read modes carried per read head in pi.
   localparam int unsigned READ_MODES = 3;

   // A field holds elements unless one of its dimensions is zero.
   function automatic logic field_nonempty(input state_t s, input logic r_zero, input logic w_zero);
      logic res;
      res = 1'b0;
      case (s)
         ST_K_READ:                         res = !r_zero && !w_zero;
         ST_BETA_READ, ST_F, ST_PI:         res = !r_zero;
         ST_K_WRITE, ST_E, ST_V:            res = !w_zero;
         ST_BETA_WRITE, ST_G_A, ST_G_W:     res = 1'b1;
         default:                           res = 1'b0;
      endcase
      return res;
   endfunction

   // First non-empty field after s in the fixed order; STARTER when none remain.
   function automatic state_t next_field(input state_t s, input logic r_zero, input logic w_zero);
      state_t res;
      logic   found;
      res   = ST_STARTER;
      found = 1'b0;
      for (int unsigned k = 1; k < NUM_STATES; k++) begin
         if (!found && (4'(k) > s) && field_nonempty(state_t'(4'(k)), r_zero, w_zero)) begin
            res   = state_t'(4'(k));
            found = 1'b1;
         end
      end
      return res;
   endfunction

   function automatic logic [3:0] field_id(input state_t s);
      logic [3:0] res;
      res = FIELD_K_READ;
      case (s)
         ST_K_READ:     res = FIELD_K_READ;
         ST_BETA_READ:  res = FIELD_BETA_READ;
         ST_K_WRITE:    res = FIELD_K_WRITE;
         ST_BETA_WRITE: res = FIELD_BETA_WRITE;
         ST_E:          res = FIELD_E;
         ST_V:          res = FIELD_V;
         ST_F:          res = FIELD_F;
         ST_G_A:        res = FIELD_G_A;
         ST_G_W:        res = FIELD_G_W;
         ST_PI:         res = FIELD_PI;
         default:       res = FIELD_K_READ;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/accelerator_interface_counter.sv
// Two-dimensional (i,j) element counter: j runs innermost up to its limit,
// then wraps and advances i; o_last flags the final element of the field.
module accelerator_interface_counter #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_i_limit,
   input  logic [WIDTH-1:0] i_j_limit,
   output logic [WIDTH-1:0] o_i,
   output logic [WIDTH-1:0] o_j,
   output logic             o_last
);

   logic [WIDTH-1:0] r_i;
   logic [WIDTH-1:0] r_j;
   logic             w_j_wrap;
   logic             w_i_wrap;

   // Wrap flags: current position is the last of its dimension.
   always_comb begin
      w_j_wrap = (r_j == i_j_limit - WIDTH'(1));
      w_i_wrap = (r_i == i_i_limit - WIDTH'(1));
   end

   // Index update: clear wins over step; both indices return to 0 after the last element.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear) begin
         r_i <= '0;
         r_j <= '0;
      end else if (i_step) begin
         if (w_j_wrap) begin
            r_j <= '0;
            r_i <= w_i_wrap ? '0 : r_i + WIDTH'(1);
         end else begin
            r_j <= r_j + WIDTH'(1);
         end
      end
   end

   assign o_i    = r_i;
   assign o_j    = r_j;
   assign o_last = w_j_wrap && w_i_wrap;

endmodule

// File: rtl/accelerator_interface_parser.sv
// Consumer of the DNC interface vector xi: tags each accepted element with
// its field id and (i,j) position, one element per cycle, latency one.
module accelerator_interface_parser
   import accelerator_dnc_pkg::*;
#(
   parameter int unsigned DATA_SIZE    = 64,
   parameter int unsigned CONTROL_SIZE = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   input  logic [DATA_SIZE-1:0] SIZE_R_IN,
   input  logic [DATA_SIZE-1:0] SIZE_W_IN,
   input  logic                 XI_IN_ENABLE,
   input  logic [DATA_SIZE-1:0] XI_IN,
   output logic [DATA_SIZE-1:0] XI_LENGTH_OUT,
   output logic                 DATA_OUT_ENABLE,
   output logic [DATA_SIZE-1:0] DATA_OUT,
   output logic [3:0]           FIELD_OUT,
   output logic [DATA_SIZE-1:0] I_OUT,
   output logic [DATA_SIZE-1:0] J_OUT
);

   state_t                  r_state;
   state_t                  w_state_next;
   state_t                  w_after;
   logic [DATA_SIZE-1:0]    r_size_r;
   logic [DATA_SIZE-1:0]    r_size_w;
   logic [DATA_SIZE-1:0]    r_xi_length;
   logic [DATA_SIZE-1:0]    w_xi_length;

   logic                    r_data_out_en;
   logic [DATA_SIZE-1:0]    r_data_out;
   logic [3:0]              r_field_out;
   logic [DATA_SIZE-1:0]    r_i_out;
   logic [DATA_SIZE-1:0]    r_j_out;
   logic                    r_ready;

   logic                    w_start;
   logic                    w_accept;
   logic                    w_field_done;
   logic                    w_ready_next;
   logic                    w_r_zero;
   logic                    w_w_zero;
   logic [CONTROL_SIZE-1:0] w_i_limit;
   logic [CONTROL_SIZE-1:0] w_j_limit;
   logic [CONTROL_SIZE-1:0] w_cnt_i;
   logic [CONTROL_SIZE-1:0] w_cnt_j;
   logic                    w_cnt_last;

   // Handshake decode and vector length N = R*W + 3W + 5R + 3 (modulo 2^DATA_SIZE).
   always_comb begin
      w_start     = START && (r_state == ST_STARTER);
      w_accept    = XI_IN_ENABLE && (r_state != ST_STARTER);
      w_r_zero    = (r_size_r == '0);
      w_w_zero    = (r_size_w == '0);
      w_xi_length = (SIZE_R_IN * SIZE_W_IN)
                  + (SIZE_W_IN << 1) + SIZE_W_IN
                  + (SIZE_R_IN << 2) + SIZE_R_IN
                  + DATA_SIZE'(3);
   end

   // Per-field counter limits: i spans read heads, j spans word positions or read modes.
   always_comb begin
      w_i_limit = '0;
      w_j_limit = '0;
      case (r_state)
         ST_K_READ: begin
            w_i_limit = CONTROL_SIZE'(r_size_r);
            w_j_limit = CONTROL_SIZE'(r_size_w);
         end
         ST_BETA_READ, ST_F: begin
            w_i_limit = CONTROL_SIZE'(r_size_r);
            w_j_limit = CONTROL_SIZE'(1);
         end
         ST_K_WRITE, ST_E, ST_V: begin
            w_i_limit = CONTROL_SIZE'(1);
            w_j_limit = CONTROL_SIZE'(r_size_w);
         end
         ST_BETA_WRITE, ST_G_A, ST_G_W: begin
            w_i_limit = CONTROL_SIZE'(1);
            w_j_limit = CONTROL_SIZE'(1);
         end
         ST_PI: begin
            w_i_limit = CONTROL_SIZE'(r_size_r);
            w_j_limit = CONTROL_SIZE'(READ_MODES);
         end
         default: begin
            w_i_limit = '0;
            w_j_limit = '0;
         end
      endcase
   end

   accelerator_interface_counter #(
      .WIDTH (CONTROL_SIZE)
   ) u_counter (
      .i_clk     (CLK),
      .i_rst_n   (RST),
      .i_clear   (w_start),
      .i_step    (w_accept),
      .i_i_limit (w_i_limit),
      .i_j_limit (w_j_limit),
      .o_i       (w_cnt_i),
      .o_j       (w_cnt_j),
      .o_last    (w_cnt_last)
   );

   // Next-state: empty fields are skipped at the transition so no cycle is spent on them.
   always_comb begin
      w_state_next = r_state;
      w_field_done = w_accept && w_cnt_last;
      w_after      = next_field(r_state, w_r_zero, w_w_zero);
      w_ready_next = w_field_done && (w_after == ST_STARTER);
      if (r_state == ST_STARTER) begin
         if (START) begin
            w_state_next = next_field(ST_STARTER, (SIZE_R_IN == '0), (SIZE_W_IN == '0));
         end
      end else if (w_field_done) begin
         w_state_next = w_after;
      end
   end

   // State register, latched sizes and vector length.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_state     <= ST_STARTER;
         r_size_r    <= '0;
         r_size_w    <= '0;
         r_xi_length <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_size_r    <= SIZE_R_IN;
            r_size_w    <= SIZE_W_IN;
            r_xi_length <= w_xi_length;
         end
      end
   end

   // Output registers: tagged copy of each accepted element, held between strobes.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         r_data_out_en <= 1'b0;
         r_data_out    <= '0;
         r_field_out   <= '0;
         r_i_out       <= '0;
         r_j_out       <= '0;
         r_ready       <= 1'b0;
      end else begin
         r_data_out_en <= w_accept;
         r_ready       <= w_ready_next;
         if (w_accept) begin
            r_data_out  <= XI_IN;
            r_field_out <= field_id(r_state);
            r_i_out     <= DATA_SIZE'(w_cnt_i);
            r_j_out     <= DATA_SIZE'(w_cnt_j);
         end
      end
   end

   assign READY           = r_ready;
   assign XI_LENGTH_OUT   = r_xi_length;
   assign DATA_OUT_ENABLE = r_data_out_en;
   assign DATA_OUT        = r_data_out;
   assign FIELD_OUT       = r_field_out;
   assign I_OUT           = r_i_out;
   assign J_OUT           = r_j_out;

endmodule

// File: tb/tb_accelerator_interface_parser.sv
// Scoreboard bench: stimulus pushes expected tagged elements, a monitor on
// the falling edge pops and compares whenever DATA_OUT_ENABLE is high.
module tb_accelerator_interface_parser;

   logic        CLK = 1'b0;
   logic        RST;
   logic        START;
   logic        READY;
   logic [63:0] SIZE_R_IN;
   logic [63:0] SIZE_W_IN;
   logic        XI_IN_ENABLE;
   logic [63:0] XI_IN;
   logic [63:0] XI_LENGTH_OUT;
   logic        DATA_OUT_ENABLE;
   logic [63:0] DATA_OUT;
   logic [3:0]  FIELD_OUT;
   logic [63:0] I_OUT;
   logic [63:0] J_OUT;

   typedef struct {
      logic [63:0] d;
      logic [3:0]  f;
      logic [63:0] i;
      logic [63:0] j;
      logic        rdy;
   } exp_t;

   typedef struct {
      logic [3:0] f;
      int         i;
      int         j;
   } fij_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   accelerator_interface_parser #(
      .DATA_SIZE    (64),
      .CONTROL_SIZE (64)
   ) dut (
      .CLK             (CLK),
      .RST             (RST),
      .START           (START),
      .READY           (READY),
      .SIZE_R_IN       (SIZE_R_IN),
      .SIZE_W_IN       (SIZE_W_IN),
      .XI_IN_ENABLE    (XI_IN_ENABLE),
      .XI_IN           (XI_IN),
      .XI_LENGTH_OUT   (XI_LENGTH_OUT),
      .DATA_OUT_ENABLE (DATA_OUT_ENABLE),
      .DATA_OUT        (DATA_OUT),
      .FIELD_OUT       (FIELD_OUT),
      .I_OUT           (I_OUT),
      .J_OUT           (J_OUT)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: every output beat must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (RST === 1'b1) begin
         if (DATA_OUT_ENABLE) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got data=%0d field=%0d, required no output", DATA_OUT, FIELD_OUT);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (DATA_OUT !== e.d || FIELD_OUT !== e.f || I_OUT !== e.i || J_OUT !== e.j || READY !== e.rdy) begin
                  n_fail++;
                  $display("FAIL element: got d=%0d f=%0d i=%0d j=%0d rdy=%0b, required d=%0d f=%0d i=%0d j=%0d rdy=%0b",
                           DATA_OUT, FIELD_OUT, I_OUT, J_OUT, READY, e.d, e.f, e.i, e.j, e.rdy);
               end
            end
         end else begin
            n_checks++;
            if (READY !== 1'b0) begin
               n_fail++;
               $display("FAIL ready_without_data: got READY=%0b, required 0", READY);
            end
         end
      end
   end

   task automatic push_exp(input logic [63:0] d, input logic [3:0] f, input int i, input int j, input logic rdy);
      exp_t e;
      e.d = d; e.f = f; e.i = 64'(i); e.j = 64'(j); e.rdy = rdy;
      q.push_back(e);
   endtask

   // Expected element order for sizes (r,w); only the first 'limit' entries are pushed.
   task automatic build_vec(input int r, input int w, input logic [63:0] base, input int limit);
      fij_t lst[$];
      fij_t x;
      for (int i = 0; i < r; i++) for (int j = 0; j < w; j++) begin x.f = 4'd0; x.i = i; x.j = j; lst.push_back(x); end
      for (int i = 0; i < r; i++) begin x.f = 4'd1; x.i = i; x.j = 0; lst.push_back(x); end
      for (int j = 0; j < w; j++) begin x.f = 4'd2; x.i = 0; x.j = j; lst.push_back(x); end
      x.f = 4'd3; x.i = 0; x.j = 0; lst.push_back(x);
      for (int j = 0; j < w; j++) begin x.f = 4'd4; x.i = 0; x.j = j; lst.push_back(x); end
      for (int j = 0; j < w; j++) begin x.f = 4'd5; x.i = 0; x.j = j; lst.push_back(x); end
      for (int i = 0; i < r; i++) begin x.f = 4'd6; x.i = i; x.j = 0; lst.push_back(x); end
      x.f = 4'd7; x.i = 0; x.j = 0; lst.push_back(x);
      x.f = 4'd8; x.i = 0; x.j = 0; lst.push_back(x);
      for (int i = 0; i < r; i++) for (int j = 0; j < 3; j++) begin x.f = 4'd9; x.i = i; x.j = j; lst.push_back(x); end
      for (int k = 0; k < lst.size() && k < limit; k++)
         push_exp(base + 64'(k), lst[k].f, lst[k].i, lst[k].j, k == lst.size() - 1);
   endtask

   task automatic check_len(input logic [63:0] req, input string name);
      n_checks++;
      if (XI_LENGTH_OUT !== req) begin
         n_fail++;
         $display("FAIL %s: got XI_LENGTH_OUT=%0d, required %0d", name, XI_LENGTH_OUT, req);
      end
   endtask

   task automatic start_vec(input int r, input int w, input logic [63:0] req_len);
      START = 1'b1; SIZE_R_IN = 64'(r); SIZE_W_IN = 64'(w);
      @(posedge CLK); #1;
      START = 1'b0; SIZE_R_IN = 64'd7; SIZE_W_IN = 64'd9;
      check_len(req_len, "xi_length");
   endtask

   task automatic send_vec(input logic [63:0] base, input int count, input int gap);
      for (int k = 0; k < count; k++) begin
         XI_IN_ENABLE = 1'b1; XI_IN = base + 64'(k);
         @(posedge CLK); #1;
         XI_IN_ENABLE = 1'b0; XI_IN = 64'hDEAD;
         repeat (gap) begin @(posedge CLK); #1; end
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 20 && q.size() != 0; c++) @(negedge CLK);
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d outputs still pending, required 0", q.size());
         q.delete();
      end
      @(posedge CLK); #1;
   endtask

   task automatic check_zero_outputs(input string name);
      n_checks++;
      if (DATA_OUT_ENABLE !== 1'b0 || DATA_OUT !== '0 || FIELD_OUT !== '0 || I_OUT !== '0 ||
          J_OUT !== '0 || READY !== 1'b0 || XI_LENGTH_OUT !== '0) begin
         n_fail++;
         $display("FAIL %s: got en=%0b d=%0d f=%0d i=%0d j=%0d rdy=%0b len=%0d, required all 0",
                  name, DATA_OUT_ENABLE, DATA_OUT, FIELD_OUT, I_OUT, J_OUT, READY, XI_LENGTH_OUT);
      end
   endtask

   initial begin
      logic [3:0] t_f [16];
      int         t_j [16];
      t_f = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd9};
      t_j = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 2};

      RST = 1'b0; START = 1'b0; XI_IN_ENABLE = 1'b0; XI_IN = '0; SIZE_R_IN = '0; SIZE_W_IN = '0;
      repeat (3) @(posedge CLK);
      #1;
      check_zero_outputs("reset_state");
      RST = 1'b1;
      @(posedge CLK); #1;

      // R=1, W=2 hand table, XI_IN = 1..16.
      for (int k = 0; k < 16; k++) push_exp(64'(k + 1), t_f[k], 0, t_j[k], k == 15);
      start_vec(1, 2, 64'd16);
      send_vec(64'd1, 16, 0);
      drain();

      // R=2, W=3: N = 6+9+10+3 = 28.
      build_vec(2, 3, 64'd100, 1000);
      start_vec(2, 3, 64'd28);
      send_vec(64'd100, 28, 0);
      drain();

      // R=0, W=0: only the three scalars.
      push_exp(64'd1000, 4'd3, 0, 0, 1'b0);
      push_exp(64'd1001, 4'd7, 0, 0, 1'b0);
      push_exp(64'd1002, 4'd8, 0, 0, 1'b1);
      start_vec(0, 0, 64'd3);
      send_vec(64'd1000, 3, 0);
      drain();

      // Gaps between strobes, START with other sizes mid-vector must be ignored.
      build_vec(1, 2, 64'd200, 1000);
      start_vec(1, 2, 64'd16);
      send_vec(64'd200, 6, 2);
      START = 1'b1; SIZE_R_IN = 64'd5; SIZE_W_IN = 64'd5;
      @(posedge CLK); #1;
      START = 1'b0;
      check_len(64'd16, "len_after_mid_start");
      send_vec(64'd206, 10, 1);
      drain();

      // Reset after 5 of 16 elements, then a fresh vector from K_READ (0,0).
      build_vec(1, 2, 64'd300, 5);
      start_vec(1, 2, 64'd16);
      send_vec(64'd300, 5, 0);
      drain();
      RST = 1'b0;
      @(posedge CLK); #1;
      check_zero_outputs("mid_vector_reset");
      RST = 1'b1;
      @(posedge CLK); #1;
      build_vec(1, 2, 64'd400, 1000);
      start_vec(1, 2, 64'd16);
      send_vec(64'd400, 16, 0);
      drain();

      // Back-to-back: START in the READY cycle, with a strobe that must be ignored.
      build_vec(1, 2, 64'd500, 1000);
      build_vec(2, 1, 64'd600, 1000);
      start_vec(1, 2, 64'd16);
      send_vec(64'd500, 16, 0);
      START = 1'b1; SIZE_R_IN = 64'd2; SIZE_W_IN = 64'd1;
      XI_IN_ENABLE = 1'b1; XI_IN = 64'd999;
      @(posedge CLK); #1;
      START = 1'b0; XI_IN_ENABLE = 1'b0;
      check_len(64'd18, "len_back_to_back");
      send_vec(64'd600, 18, 0);
      drain();

      repeat (3) @(posedge CLK);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
